// File: rtl/life_pkg.sv
// life_pkg
//   Shared definitions for the Game-of-Life engine: board geometry, FSM
//   state type and the cell-index helper that maps (row, col) onto the
//   quadrant-packed board bit layout.
//   Layout: col = {qx, c[1:0]}, row = {qy, r[1:0]},
//           bit = {qx,qy}*16 + c*4 + r.
package life_pkg;

    localparam int BOARD_W = 8;
    localparam int CELLS   = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Row/col are taken as plain integers so callers can pass r-1 / c+1
    // directly; keeping only the low three bits gives the mod-8 torus wrap
    // (two's complement makes -1 land on 7).
    function automatic logic [5:0] cell_idx(input int row, input int col);
        logic [2:0] r;
        logic [2:0] c;
        r = 3'(row);
        c = 3'(col);
        return {c[2], r[2], c[1:0], r[1:0]};
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// life_cell_rule
//   Combinational B3/S23 rule for one cell.
//   Ports:
//     nbr        in  8  the eight neighbour cells (any order)
//     self_alive in  1  current state of the cell
//     next_alive out 1  state of the cell in the next generation
module life_cell_rule (
    input  logic [7:0] nbr,
    input  logic       self_alive,
    output logic       next_alive
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(nbr[i]);
        end
    end

    // Born with exactly three neighbours; survives with two or three.
    assign next_alive = (count == 4'd3) | (self_alive & (count == 4'd2));

endmodule

// File: rtl/life_engine.sv
// life_engine
//   Game-of-Life generation engine on an 8x8 toroidal board. Holds the
//   current and previous generation for the renderer and computes new
//   generations serially, one cell per clock, into a shadow board that is
//   committed in a single cycle.
//   Ports:
//     clk         in  1   system/pixel clock
//     rst_n       in  1   synchronous active-low reset
//     frame_start in  1   pulse at start of vertical blank
//     run         in  1   free-run at GEN_DIV frames per generation
//     step        in  1   pulse: one generation (only when run=0)
//     load        in  1   pulse: replace board with seed
//     seed        in  64  board image in internal layout
//     array_pos   in  2   quadrant select {qx,qy}
//     alive       out 16  current generation, selected quadrant
//     alive_prev  out 16  previous generation, selected quadrant
//     busy        out 1   high while computing or committing
//     generation  out 16  generation counter
module life_engine
    import life_pkg::*;
#(
    parameter int GEN_DIV = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             run,
    input  logic             step,
    input  logic             load,
    input  logic [CELLS-1:0] seed,
    input  logic [1:0]       array_pos,
    output logic [15:0]      alive,
    output logic [15:0]      alive_prev,
    output logic             busy,
    output logic [15:0]      generation
);

    localparam int CNT_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GEN_DIV - 1);

    logic [CELLS-1:0] cur;
    logic [CELLS-1:0] prev;
    logic [CELLS-1:0] shadow;
    logic [15:0]      gen;
    logic [5:0]       idx;
    logic [CNT_W-1:0] frame_cnt;
    state_t           state;

    logic             tick;
    logic [7:0]       nbr;
    logic             next_alive;
    int               row_i;
    int               col_i;

    // Generation tick: frame divider in free-run, manual step otherwise.
    always_comb begin
        tick = 1'b0;
        if (run) begin
            tick = frame_start && (frame_cnt == CNT_LAST);
        end else begin
            tick = step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || load || !run) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
        end
    end

    // Neighbour gather for the cell under evaluation; idx is decoded back
    // into (row, col) and the eight wrapped neighbours are picked from cur.
    assign row_i = int'({idx[4], idx[1:0]});
    assign col_i = int'({idx[5], idx[3:2]});

    assign nbr = {
        cur[cell_idx(row_i - 1, col_i - 1)], cur[cell_idx(row_i - 1, col_i)],
        cur[cell_idx(row_i - 1, col_i + 1)], cur[cell_idx(row_i, col_i - 1)],
        cur[cell_idx(row_i, col_i + 1)],     cur[cell_idx(row_i + 1, col_i - 1)],
        cur[cell_idx(row_i + 1, col_i)],     cur[cell_idx(row_i + 1, col_i + 1)]
    };

    life_cell_rule u_rule (
        .nbr        (nbr),
        .self_alive (cur[idx]),
        .next_alive (next_alive)
    );

    // Sequencer: load aborts any in-flight generation without committing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur    <= '0;
            prev   <= '0;
            shadow <= '0;
            gen    <= '0;
            idx    <= '0;
            state  <= IDLE;
        end else if (load) begin
            cur   <= seed;
            prev  <= seed;
            gen   <= '0;
            idx   <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        idx   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    shadow[idx] <= next_alive;
                    idx         <= idx + 6'd1;
                    if (idx == 6'd63) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    prev  <= cur;
                    cur   <= shadow;
                    gen   <= gen + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Renderer readback is combinational so it lines up with its pixel.
    assign alive      = cur[{array_pos, 4'b0000} +: 16];
    assign alive_prev = prev[{array_pos, 4'b0000} +: 16];
    assign busy       = (state != IDLE);
    assign generation = gen;

endmodule
